i2s_tx: RTL

- Output stage directly downstream of the 3-band equalizer top.
- Accepts the equalizer's 24-bit signed mono sample through a valid/ready handshake.
- Serialises the sample to an external audio DAC in I2S format, with the same sample sent on the left and right slots.
- Generates BCLK and LRCK internally by dividing the system clock; no second clock domain.

---
 rtl/eq_audio_pkg.sv | 28 ++
 rtl/i2s_clk_gen.sv | 86 ++++++++
 rtl/i2s_tx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/eq_audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eq_audio_pkg
// Description : Shared types and constants for the equalizer audio path and
//               its I2S output stage.
//               Contents:
//                 sample_t      - signed 24-bit mono audio sample
//                 AUDIO_DATA_W  - sample width (24)
//                 I2S_SLOT_W    - BCLK periods per channel slot (32)
//                 I2S_BCLK_DIV  - clk cycles per BCLK period (4)
//                 cnt_w()       - counter width for a 0..N-1 counter
// Revision    : 1.0 - initial release
// ============================================================================
package eq_audio_pkg;

  localparam int AUDIO_DATA_W = 24;
  localparam int I2S_SLOT_W   = 32;
  localparam int I2S_BCLK_DIV = 4;

  typedef logic signed [AUDIO_DATA_W-1:0] sample_t;

  // Width of a counter that runs 0..max_val-1; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val <= 2) ? 1 : $clog2(max_val);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2s_clk_gen
// Description : Divides clk into the I2S bit clock and word select, and
//               provides the bit-position timing used by the serialiser.
//               Ports:
//                 clk       in   system clock
//                 reset_n   in   asynchronous active-low reset
//                 fe_pulse  out  high in the clk cycle where div_cnt wraps
//                                (the edge that ends it is a BCLK fall)
//                 fs_pulse  out  fe_pulse that also wraps bit_cnt (frame start)
//                 bit_cnt   out  current bit position in frame, 0..2*SLOT_W-1
//                 bclk_o    out  registered bit clock, 50% duty
//                 lrck_o    out  registered word select, 0 = left, 1 = right
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_clk_gen
  import eq_audio_pkg::*;
#(
  parameter int  SLOT_W   = I2S_SLOT_W,
  parameter int  BCLK_DIV = I2S_BCLK_DIV,
  localparam int BIT_W    = cnt_w(2 * SLOT_W)
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             fe_pulse,
  output logic             fs_pulse,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             bclk_o,
  output logic             lrck_o
);

  localparam int DIV_W = cnt_w(BCLK_DIV);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bclk_q, bclk_d;
  logic             lrck_q, lrck_d;
  logic             fe, fs;

  always_comb begin
    fe = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
    fs = fe && (bit_cnt_q == BIT_W'(2 * SLOT_W - 1));

    div_cnt_d = fe ? '0 : div_cnt_q + 1'b1;

    bit_cnt_d = bit_cnt_q;
    if (fs) begin
      bit_cnt_d = '0;
    end else if (fe) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    // Registered from the next divider value so bclk_o tracks div_cnt_q
    // exactly: low for the first half of the period, high for the second.
    bclk_d = (div_cnt_d >= DIV_W'(BCLK_DIV / 2));

    // Word select moves only on the BCLK falling edge, together with data.
    lrck_d = lrck_q;
    if (fe) begin
      lrck_d = (bit_cnt_d >= BIT_W'(SLOT_W));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrck_q    <= lrck_d;
    end
  end

  assign fe_pulse = fe;
  assign fs_pulse = fs;
  assign bit_cnt  = bit_cnt_q;
  assign bclk_o   = bclk_q;
  assign lrck_o   = lrck_q;

endmodule
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx
// Description : I2S transmitter for the equalizer output. Takes one signed
//               mono sample per frame through a valid/ready handshake and
//               sends it on both the left and right slots. BCLK and LRCK are
//               derived from clk; there is no second clock domain.
//               Build option:
//                 I2S_TX_LJ_EN  defined   -> left-justified (MSB at slot
//                                            position 0, DATA_W <= SLOT_W)
//                               undefined -> standard I2S, MSB one BCLK after
//                                            the LRCK change (DATA_W < SLOT_W)
//               Ports:
//                 clk         in   system clock
//                 reset_n     in   asynchronous active-low reset
//                 data_in     in   signed sample from the equalizer
//                 in_valid    in   data_in is valid
//                 in_ready    out  holding register empty, sample accepted
//                 bclk_o      out  I2S bit clock
//                 lrck_o      out  word select, 0 = left, 1 = right
//                 sdata_o     out  serial data, MSB first
//                 underrun_o  out  one-cycle pulse when a frame starts with
//                                  no sample held (frame sent as zeros)
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx
  import eq_audio_pkg::*;
#(
  parameter int DATA_W   = AUDIO_DATA_W,
  parameter int SLOT_W   = I2S_SLOT_W,
  parameter int BCLK_DIV = I2S_BCLK_DIV
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     bclk_o,
  output logic                     lrck_o,
  output logic                     sdata_o,
  output logic                     underrun_o
);

  localparam int BIT_W = cnt_w(2 * SLOT_W);

  // Slot position that carries the sample MSB.
`ifdef I2S_TX_LJ_EN
  localparam int MSB_POS = 0;
`else
  localparam int MSB_POS = 1;
`endif

  logic             fe, fs;
  logic [BIT_W-1:0] bit_cnt;

  logic signed [DATA_W-1:0] hold_q, hold_d;
  logic                     hold_full_q, hold_full_d;
  logic signed [DATA_W-1:0] frame_q, frame_d;
  logic                     sdata_q, sdata_d;
  logic                     underrun_q, underrun_d;

  logic             xfer;
  logic [BIT_W-1:0] bit_nxt;
  logic [BIT_W-1:0] slot_pos;
  logic [DATA_W-1:0] bit_hit;

  i2s_clk_gen #(
    .SLOT_W   (SLOT_W),
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .fe_pulse (fe),
    .fs_pulse (fs),
    .bit_cnt  (bit_cnt),
    .bclk_o   (bclk_o),
    .lrck_o   (lrck_o)
  );

  assign in_ready = !hold_full_q;
  assign xfer     = in_valid && !hold_full_q;

  // Hold / frame registers. The frame-start decision looks at the hold state
  // before any same-cycle transfer, so a sample arriving exactly at frame
  // start is kept for the following frame.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    frame_d     = frame_q;
    underrun_d  = 1'b0;

    if (fs) begin
      if (hold_full_q) begin
        frame_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        frame_d    = '0;
        underrun_d = 1'b1;
      end
    end

    // Cannot coincide with a load above: xfer needs hold_full_q == 0.
    if (xfer) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

  // Position within the slot that becomes current after this falling edge.
  always_comb begin
    bit_nxt = fs ? '0 : bit_cnt + 1'b1;
    if (bit_nxt >= BIT_W'(SLOT_W)) begin
      slot_pos = bit_nxt - BIT_W'(SLOT_W);
    end else begin
      slot_pos = bit_nxt;
    end
  end

  // Bit i of the frame is sent at slot position MSB_POS + DATA_W-1-i; every
  // position outside that window carries zero padding. frame_d is used so a
  // freshly loaded frame is visible at position 0 in left-justified builds.
  for (genvar i = 0; i < DATA_W; i++) begin : g_sdata_map
    assign bit_hit[i] = frame_d[i] && (slot_pos == BIT_W'(MSB_POS + DATA_W - 1 - i));
  end

  always_comb begin
    sdata_d = sdata_q;
    if (fe) begin
      sdata_d = |bit_hit;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      frame_q     <= '0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      frame_q     <= frame_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
    end
  end

  assign sdata_o    = sdata_q;
  assign underrun_o = underrun_q;

endmodule
`default_nettype wire
